// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// Accepts one M-extension op while idle, runs a 32-step shift-add multiply or
// restoring divide on operand magnitudes, then presents a sign-corrected result
// for one cycle. Divide-by-zero and signed overflow finish without iterating.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   StartE        E-stage holds an M op (held while the instruction sits in E)
//   MulDivOpE     funct3 of the M op
//   SrcAE, SrcBE  forwarded rs1 / rs2 operands
//   FlushE        E-stage flush; aborts any operation
//   StallMD       combinational stall request to the hazard unit
//   ResultValidE  one-cycle pulse while ResultMDE belongs to the E-stage op
//   ResultMDE     registered result, held until the next completion
module muldiv_seq #(
  parameter int unsigned XLEN = 32,  // only 32 is supported
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            ResultValidE,
  output logic [XLEN-1:0] ResultMDE
);

  localparam int unsigned CntW = $clog2(ITER);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state, w_state_nxt;

  logic [2:0]      r_op;
  logic [31:0]     r_a;     // multiplicand, or dividend shifted out MSB first
  logic [31:0]     r_b;     // multiplier or divisor magnitude
  logic            r_neg;   // recorded result sign
  logic [CntW-1:0] r_cnt;
  logic [63:0]     r_acc;
  logic [31:0]     r_rem;
  logic [31:0]     r_quo;
  logic            r_valid;
  logic [31:0]     r_res;

  // Accept-time decode
  logic        w_accept, w_a_signed, w_b_signed, w_sign, w_div0, w_ovf, w_special;
  logic [31:0] w_mag_a, w_mag_b, w_spec_val;

  always_comb begin
    w_accept   = (r_state == StIdle) & StartE & ~FlushE;
    // MUL/MULH/MULHSU/DIV/REM treat A as signed; MUL/MULH/DIV/REM treat B as signed
    w_a_signed = MulDivOpE[2] ? ~MulDivOpE[0] : (MulDivOpE[1:0] != 2'b11);
    w_b_signed = MulDivOpE[2] ? ~MulDivOpE[0] : ~MulDivOpE[1];
    if (MulDivOpE[2]) begin
      // DIV: A^B, REM: A, unsigned: 0
      w_sign = ~MulDivOpE[0] & (MulDivOpE[1] ? SrcAE[31] : (SrcAE[31] ^ SrcBE[31]));
    end else begin
      w_sign = (w_a_signed & SrcAE[31]) ^ (w_b_signed & SrcBE[31]);
    end
    w_mag_a    = (w_a_signed & SrcAE[31]) ? -SrcAE : SrcAE;
    w_mag_b    = (w_b_signed & SrcBE[31]) ? -SrcBE : SrcBE;
    w_div0     = MulDivOpE[2] & (SrcBE == 32'h0);
    w_ovf      = MulDivOpE[2] & ~MulDivOpE[0] & (SrcAE == 32'h8000_0000) &
                 (SrcBE == 32'hFFFF_FFFF);
    w_special  = w_div0 | w_ovf;
    if (w_div0) begin
      w_spec_val = MulDivOpE[1] ? SrcAE : 32'hFFFF_FFFF;
    end else begin
      w_spec_val = MulDivOpE[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  // One iteration of either algorithm, plus the result it would give if last
  logic            w_last;
  logic [63:0]     w_acc_nxt, w_prod;
  logic [32:0]     w_rem_sh, w_diff;
  logic            w_qbit;
  logic [31:0]     w_rem_nxt, w_quo_nxt, w_q, w_r, w_result;

  always_comb begin
    w_last    = (r_cnt == CntW'(ITER - 1));
    w_acc_nxt = r_b[r_cnt] ? (r_acc + ({32'h0, r_a} << r_cnt)) : r_acc;
    w_rem_sh  = {r_rem, r_a[31]};
    w_diff    = w_rem_sh - {1'b0, r_b};
    w_qbit    = ~w_diff[32];  // no borrow: divisor fits, keep the difference
    w_rem_nxt = w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
    w_quo_nxt = {r_quo[30:0], w_qbit};
    w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_q       = r_neg ? -w_quo_nxt : w_quo_nxt;
    w_r       = r_neg ? -w_rem_nxt : w_rem_nxt;
    unique case (r_op)
      3'b000:                 w_result = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod[63:32];
      3'b100, 3'b101:         w_result = w_q;
      default:                w_result = w_r;
    endcase
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    StallMD     = 1'b0;
    unique case (r_state)
      StIdle: begin
        StallMD = w_accept;
        if (w_accept) begin
          w_state_nxt = w_special ? StDone : StRun;
        end
      end
      StRun: begin
        StallMD = 1'b1;
        if (FlushE) begin
          w_state_nxt = StIdle;
        end else if (w_last) begin
          w_state_nxt = StDone;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath. The result registers load on the edge into DONE so that the
  // valid pulse and data coincide with the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= 3'h0;
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= 64'h0;
      r_rem   <= 32'h0;
      r_quo   <= 32'h0;
      r_valid <= 1'b0;
      r_res   <= 32'h0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_op  <= MulDivOpE;
        r_a   <= w_mag_a;
        r_b   <= w_mag_b;
        r_neg <= w_sign;
        r_cnt <= '0;
        r_acc <= 64'h0;
        r_rem <= 32'h0;
        r_quo <= 32'h0;
        if (w_special) begin
          r_res   <= w_spec_val;
          r_valid <= 1'b1;
        end
      end else if ((r_state == StRun) && !FlushE) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_op[2]) begin
          r_a   <= {r_a[30:0], 1'b0};
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
        end else begin
          r_acc <= w_acc_nxt;
        end
        if (w_last) begin
          r_res   <= w_result;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign ResultValidE = r_valid;
  assign ResultMDE    = r_res;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver pushes the reference result of
// each issued op into a queue, and a negedge monitor pops and compares on
// every ResultValidE pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        StallMD;
  logic        ResultValidE;
  logic [31:0] ResultMDE;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .StartE       (StartE),
    .MulDivOpE    (MulDivOpE),
    .SrcAE        (SrcAE),
    .SrcBE        (SrcBE),
    .FlushE       (FlushE),
    .StallMD      (StallMD),
    .ResultValidE (ResultValidE),
    .ResultMDE    (ResultMDE)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    logic            ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ResultValidE) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got result %08h with nothing outstanding at %0t",
                 ResultMDE, $time);
      end else begin
        check("result", ResultMDE, exp_q.pop_front());
      end
    end
  end

  // Holds the op in E until the sequencer stops stalling, then lets it advance.
  // StartE is left high; the caller either issues the next op or drops it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int  stalls;
    bit  special;
    special = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    last_exp = ref_md(op, a, b);
    exp_q.push_back(last_exp);
    StartE    = 1'b1;
    MulDivOpE = op;
    SrcAE     = a;
    SrcBE     = b;
    stalls    = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!StallMD) break;
      stalls++;
    end
    check("stall_cycles", stalls, special ? 32'd1 : 32'd33);
    check("valid_at_done", {31'h0, ResultValidE}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    StartE = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts a DIV and kills it at T+10 with FlushE or rst
  task automatic abort_op(input bit use_rst);
    StartE    = 1'b1;
    MulDivOpE = 3'b100;
    SrcAE     = 32'hFFFF_FFEC;
    SrcBE     = 32'd6;
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else FlushE = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    FlushE = 1'b0;
    StartE = 1'b0;
    if (use_rst) last_exp = 32'h0;
    @(negedge clk);
    check(use_rst ? "rst_stall" : "flush_stall", {31'h0, StallMD}, 32'h0);
    check(use_rst ? "rst_valid" : "flush_valid", {31'h0, ResultValidE}, 32'h0);
    check(use_rst ? "rst_result" : "flush_result", ResultMDE, last_exp);
    idle(40);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, %0d outstanding", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    StartE    = 1'b0;
    MulDivOpE = 3'h0;
    SrcAE     = 32'h0;
    SrcBE     = 32'h0;
    FlushE    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {31'h0, ResultValidE}, 32'h0);
    check("reset_result", ResultMDE, 32'h0);
    check("reset_stall", {31'h0, StallMD}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Directed cases
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD);   idle(1);
    run_op(3'b001, 32'd7, 32'hFFFF_FFFD);   idle(1);
    run_op(3'b011, 32'd7, 32'hFFFF_FFFD);   idle(1);
    run_op(3'b100, 32'hFFFF_FFEC, 32'd6);   idle(1);
    run_op(3'b110, 32'hFFFF_FFEC, 32'd6);   idle(1);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd2);   idle(1);
    run_op(3'b101, 32'd5, 32'd0);           idle(1);
    run_op(3'b111, 32'd5, 32'd0);           idle(1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF); idle(1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF); idle(1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(1);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(1);

    // Back-to-back MULs with StartE held through DONE
    run_op(3'b000, 32'd12345, 32'hFFFF_0001);
    run_op(3'b000, 32'h8000_0000, 32'd3);
    idle(3);

    abort_op(1'b0);
    abort_op(1'b1);

    // Randomized ops, sometimes back-to-back, sometimes with idle gaps
    for (int i = 0; i < 120; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(5);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL outstanding: got %0d results never delivered, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
